// File: rtl/penc_seg_scan.sv
// penc_seg_scan: registered highest-bit priority encoder driving a scanned hex seven-segment display
module penc_seg_scan #(
  parameter int IN_W           = 16,
  parameter int OUT_W          = 4,
  parameter int DIGITS         = 2,
  parameter int SCAN_DIV       = 1000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              hold,
  input  logic [IN_W-1:0]   code,
  output logic [OUT_W-1:0]  result,
  output logic              valid,
  output logic              changed,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] dig_sel
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int XW = DIGITS * 4 > OUT_W ? DIGITS * 4 : OUT_W;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] BLANK = SEG_ACTIVE_LOW != 0 ? 7'h7f : 7'h00;
  logic [CW-1:0]    cnt, cnt_n;
  logic [DW-1:0]    dig, dig_n;
  logic [OUT_W-1:0] idx, res_n;
  logic             val_n, wrap;
  logic [XW-1:0]    rx;
  logic [3:0]       nib;
  logic [6:0]       g, seg_n;
  always_comb begin
    idx = '0;
    for (int i = 0; i < IN_W; i++)
      if (code[i]) idx = OUT_W'(i);
  end
  assign val_n = hold ? valid : en & |code;
  assign res_n = hold ? result : (val_n ? idx : '0);
  assign wrap  = cnt == CW'(SCAN_DIV - 1);
  assign cnt_n = wrap ? '0 : cnt + 1'b1;
  assign dig_n = wrap ? (dig == DW'(DIGITS - 1) ? '0 : dig + 1'b1) : dig;
  // seg is built from the next-state result and digit so it always agrees with the registered outputs
  assign rx    = XW'(res_n);
  assign nib   = rx[4*dig_n +: 4];
  assign g     = GLYPH[nib];
  assign seg_n = val_n ? (SEG_ACTIVE_LOW != 0 ? g : ~g) : BLANK;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result  <= '0;
      valid   <= 1'b0;
      changed <= 1'b0;
      cnt     <= '0;
      dig     <= '0;
      dig_sel <= DIGITS'(1);
      seg     <= BLANK;
    end else begin
      result  <= res_n;
      valid   <= val_n;
      changed <= !hold && {val_n, res_n} != {valid, result};
      cnt     <= cnt_n;
      dig     <= dig_n;
      dig_sel <= DIGITS'(1) << dig_n;
      seg     <= seg_n;
    end
  end
endmodule
